// File: rtl/srp16_pkg.sv
// SRP16 shared definitions: bus widths, responder FSM states
// and the latched request bundle.
package srp16_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/srp16_mem_responder_if.sv
// SRP16 data-memory port: request handshake plus one-cycle response.
// master = core side, slave = memory responder side.
interface srp16_mem_responder_if;
    import srp16_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/srp16_sp_ram.sv
// Single-port synchronous RAM: one write or one read per edge.
// The read register clears on reset; the array does not.
module srp16_sp_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/srp16_mem_responder.sv
// SRP16 data-memory responder with programmable wait states.
// Optional range check: SRP16_MEM_ADDR_CHECK_EN.
module srp16_mem_responder
    import srp16_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    srp16_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS_M1 =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t            state;
    logic [3:0]        cnt;
    req_t              req_q;
    req_t              req_in;
    req_t              acc;
    logic              enter_resp;
    logic              acc_err;
    logic              resp_valid_q;
    logic              zero_q;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;

    assign req_in = '{
        we:    bus.req_we,
        addr:  bus.req_addr,
        wdata: bus.req_wdata
    };

    // With zero wait states the access edge is the accept edge,
    // so the live request fields feed the RAM directly.
    assign acc = (state == IDLE) ? req_in : req_q;

    always_comb begin
        enter_resp = 1'b0;
        unique case (state)
            IDLE:    enter_resp = bus.req_valid && (WAIT_STATES == 0);
            WAIT:    enter_resp = (cnt == 4'd0);
            default: enter_resp = 1'b0;
        endcase
    end

`ifdef SRP16_MEM_ADDR_CHECK_EN
    logic err_q;

    assign acc_err = ({16'd0, acc.addr} >= 32'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= enter_resp && acc_err;
        end
    end

    assign bus.resp_err = err_q;
`else
    logic unused_hi;

    assign acc_err      = 1'b0;
    assign unused_hi    = ^acc.addr;
    assign bus.resp_err = 1'b0;
`endif

    assign ram_en = enter_resp && reset && !acc_err;

    srp16_sp_ram #(
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (acc.we),
        .addr  (acc.addr[IDX_W-1:0]),
        .wdata (acc.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            resp_valid_q <= enter_resp;
            if (enter_resp && !acc.we) begin
                zero_q <= acc_err;
            end
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q <= req_in;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WS_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE) && reset;
    assign bus.resp_valid = resp_valid_q;
    // A failed-range load reads as zero until the next good load.
    assign bus.resp_rdata = zero_q ? '0 : ram_rdata;

endmodule
